// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle RV32I core: sequences the shared datapath and
// stalls on memReady for every memory access. Outputs are decoded from state.
module multicycle_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       memReady,
    output logic       pcWrite,
    output logic       adrSrc,
    output logic       irWrite,
    output logic       memWrite,
    output logic       regWrite,
    output logic [1:0] resultSrc,
    output logic [1:0] aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [1:0] immSrc,
    output logic [2:0] aluControl
);

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_ALUI = 7'b0010011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECUTER, EXECUTEI, LUI, JAL, ALUWB
    } state_t;

    state_t     state;
    state_t     next_state;
    logic [1:0] alu_op;
    logic       pc_wr;
    logic       ir_wr;
    logic       mem_wr;
    logic       reg_wr;

    always_ff @(posedge clk) begin
        if (reset) state <= FETCH;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            FETCH:    if (memReady) next_state = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: next_state = MEMADR;
                    OP_R:         next_state = EXECUTER;
                    OP_ALUI:      next_state = EXECUTEI;
                    OP_LUI:       next_state = LUI;
                    OP_JAL:       next_state = JAL;
                    default:      next_state = FETCH;
                endcase
            end
            MEMADR:   next_state = (op == OP_LW) ? MEMREAD : MEMWRITE;
            MEMREAD:  if (memReady) next_state = MEMWB;
            MEMWB:    next_state = FETCH;
            MEMWRITE: if (memReady) next_state = FETCH;
            EXECUTER: next_state = ALUWB;
            EXECUTEI: next_state = ALUWB;
            LUI:      next_state = ALUWB;
            JAL:      next_state = ALUWB;
            ALUWB:    next_state = FETCH;
            default:  next_state = FETCH;
        endcase
    end

    always_comb begin
        pc_wr     = 1'b0;
        ir_wr     = 1'b0;
        mem_wr    = 1'b0;
        reg_wr    = 1'b0;
        adrSrc    = 1'b0;
        resultSrc = 2'b00;
        aluSrcA   = 2'b00;
        aluSrcB   = 2'b00;
        alu_op    = 2'b00;
        case (state)
            FETCH: begin
                aluSrcB   = 2'b10;
                resultSrc = 2'b10;
                ir_wr     = memReady;
                pc_wr     = memReady;
            end
            DECODE: begin
                aluSrcA = 2'b01;
                aluSrcB = 2'b01;
            end
            MEMADR: begin
                aluSrcA = 2'b10;
                aluSrcB = 2'b01;
            end
            MEMREAD:  adrSrc = 1'b1;
            MEMWB: begin
                resultSrc = 2'b01;
                reg_wr    = 1'b1;
            end
            MEMWRITE: begin
                adrSrc = 1'b1;
                mem_wr = 1'b1;
            end
            EXECUTER: begin
                aluSrcA = 2'b10;
                alu_op  = 2'b10;
            end
            EXECUTEI: begin
                aluSrcA = 2'b10;
                aluSrcB = 2'b01;
                alu_op  = 2'b10;
            end
            LUI: begin
                aluSrcA = 2'b11;
                aluSrcB = 2'b01;
            end
            JAL: begin
                aluSrcA = 2'b01;
                aluSrcB = 2'b10;
                pc_wr   = 1'b1;
            end
            ALUWB:    reg_wr = 1'b1;
            default:  ;
        endcase
    end

    // Reset masks every write enable so an abandoned instruction leaves no trace.
    assign pcWrite  = pc_wr  & ~reset;
    assign irWrite  = ir_wr  & ~reset;
    assign memWrite = mem_wr & ~reset;
    assign regWrite = reg_wr & ~reset;

    always_comb begin
        case (op)
            OP_LUI:  immSrc = 2'b01;
            OP_JAL:  immSrc = 2'b10;
            OP_SW:   immSrc = 2'b11;
            default: immSrc = 2'b00;
        endcase
    end

    always_comb begin
        aluControl = 3'b000;
        if (alu_op == 2'b01) begin
            aluControl = 3'b001;
        end else if (alu_op == 2'b10) begin
            case (funct3)
                3'b000:  aluControl = (op == OP_R && funct7b5) ? 3'b001 : 3'b000;
                3'b010:  aluControl = 3'b101;
                3'b110:  aluControl = 3'b011;
                3'b111:  aluControl = 3'b010;
                default: aluControl = 3'b000;
            endcase
        end
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Control FSM for the multicycle version of the RV32I core. Sequences the shared datapath (PC, instruction/data memory port, register file, ALU, sign-extension unit) over several cycles per instruction. Generates per-state enables, mux selects, the sign-extender's `immSrc` and the ALU operation. Adds a `memReady` wait handshake on every memory access.

## Interface
Parameters: none.

Ports:
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high. One clock; reset is synchronous and active-high.
- `op` in 7: opcode, instr[6:0], taken from the instruction register.
- `funct3` in 3: instr[14:12].
- `funct7b5` in 1: instr[30].
- `memReady` in 1: memory completes the current access on this rising edge.
- `pcWrite` out 1: PC load enable.
- `adrSrc` out 1: memory address select. 0 = PC; 1 = aluOut.
- `irWrite` out 1: instruction register and oldPC load enable.
- `memWrite` out 1: data memory write request.
- `regWrite` out 1: register file write enable.
- `resultSrc` out 2: result bus select. 00 = aluOut; 01 = data register; 10 = ALU result.
- `aluSrcA` out 2: ALU operand A select. 00 = PC; 01 = oldPC; 10 = rd1; 11 = zero.
- `aluSrcB` out 2: ALU operand B select. 00 = rd2; 01 = immExt; 10 = constant 4.
- `immSrc` out 2: sign-extender format select. 00 = I; 01 = U; 10 = J; 11 = S.
- `aluControl` out 3: ALU operation. 000 = add; 001 = sub; 010 = and; 011 = or; 101 = slt.

## Operation
- Supported instructions: lw (0000011), I-ALU (0010011), sw (0100011), R-type (0110011), lui (0110111), jal (1101111).
  - Any other opcode is illegal: DECODE → FETCH, with no writes.
- `immSrc` is decoded combinationally from `op` in every state:
  - lui → 01.
  - jal → 10.
  - sw → 11.
  - All others → 00.
- Internal 2-bit `aluOp`: 00 = add, 01 = sub, 10 = use funct fields.
- `aluControl` when `aluOp` = 10:
  - funct3 000: sub only if op = R-type and `funct7b5` = 1, otherwise add.
  - funct3 010: slt.
  - funct3 110: or.
  - funct3 111: and.
  - Any other funct3: add.
- Unless a state lists them, outputs default to: all enables 0, all selects 00, `aluOp` = 00.
- States, their outputs, and transitions:
  - **FETCH**: `adrSrc` = 0, `aluSrcA` = 00, `aluSrcB` = 10, `resultSrc` = 10, `irWrite` = `pcWrite` = `memReady`. Go to DECODE if `memReady`, else stay.
  - **DECODE**: `aluSrcA` = 01, `aluSrcB` = 01 (computes oldPC + imm for jal). Next state by opcode:
    - lw, sw → MEMADR.
    - R-type → EXECUTER.
    - I-ALU → EXECUTEI.
    - lui → LUI.
    - jal → JAL.
    - else → FETCH.
  - **MEMADR**: `aluSrcA` = 10, `aluSrcB` = 01. Go to MEMREAD for lw, MEMWRITE for sw.
  - **MEMREAD**: `adrSrc` = 1, `resultSrc` = 00. Go to MEMWB if `memReady`, else stay.
  - **MEMWB**: `resultSrc` = 01, `regWrite` = 1. Go to FETCH.
  - **MEMWRITE**: `adrSrc` = 1, `resultSrc` = 00, `memWrite` = 1. Hold until `memReady`, then FETCH.
  - **EXECUTER**: `aluSrcA` = 10, `aluSrcB` = 00, `aluOp` = 10. Go to ALUWB.
  - **EXECUTEI**: `aluSrcA` = 10, `aluSrcB` = 01, `aluOp` = 10. Go to ALUWB.
  - **LUI**: `aluSrcA` = 11, `aluSrcB` = 01. Go to ALUWB.
  - **JAL**: `aluSrcA` = 01, `aluSrcB` = 10, `resultSrc` = 00, `pcWrite` = 1. Go to ALUWB.
  - **ALUWB**: `resultSrc` = 00, `regWrite` = 1. Go to FETCH.

## Timing
- The state register is the only storage; it updates on the rising edge of `clk`.
- All outputs are combinational from the state, `op`, `funct3`, `funct7b5` and `memReady`. There is no output register.
- Reset:
  - `reset` high at an edge → state = FETCH.
  - While `reset` is high, `pcWrite`, `irWrite`, `memWrite` and `regWrite` are forced to 0, regardless of state or `memReady`.
  - Reset asserted mid-instruction abandons the instruction. No partial write occurs after that edge.
- Memory handshake:
  - A request is held with stable outputs until an edge where `memReady` = 1. That edge completes the access.
  - Each wait cycle adds exactly one cycle of latency.
  - `memWrite` never pulses twice for one sw.
- Cycles per instruction with `memReady` held at 1:
  - lw: 5.
  - sw: 4.
  - R-type, I-ALU, lui, jal: 4.
  - Illegal opcode: 2.
- `regWrite` is high for exactly one cycle per register-writing instruction.
- `pcWrite` is high for one cycle in FETCH, plus one cycle in JAL for jal.

## Test plan
- **Reset**: hold `reset` for 2 cycles with `memReady` = 1 → state FETCH, all four enables 0 during reset. The first post-reset edge asserts `irWrite` = `pcWrite` = 1.
- **R-type sub**:
  - Stimulus: op 0110011, funct3 000, `funct7b5` = 1.
  - Required response: 4-cycle sequence FETCH, DECODE, EXECUTER, ALUWB.
  - `aluControl` = 001 in EXECUTER; `regWrite` = 1 only in ALUWB.
- **lw with 2 wait cycles in MEMREAD**: 7 cycles total. `adrSrc` = 1 held for 3 cycles, `immSrc` = 00, `resultSrc` = 01 in MEMWB.
- **sw**: `immSrc` = 11; `memWrite` high for exactly the cycles spent in MEMWRITE; `regWrite` never asserted.
- **jal**:
  - `immSrc` = 10 in DECODE.
  - JAL state drives `pcWrite` = 1 with `aluSrcA` = 01 and `aluSrcB` = 10.
  - ALUWB drives `regWrite` = 1.
- **Illegal op and lui**:
  - Illegal op 1111111 → FETCH after DECODE with zero writes.
  - lui: `immSrc` = 01, `aluSrcA` = 11, `aluControl` = 000.
